// File: rtl/operand_sequencer.sv
// Collects eight operand words, pulses start to a compute core, waits for done
// (bounded by TIMEOUT) and hands the captured result downstream with valid/ready.
module operand_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             start,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] i4,
  output logic [WIDTH-1:0] i5,
  output logic [WIDTH-1:0] i6,
  output logic [WIDTH-1:0] i7,
  output logic [WIDTH-1:0] i8,
  input  logic [WIDTH-1:0] result,
  input  logic             done,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, LAUNCH, WAIT, DELIVER} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [WIDTH-1:0] ops_q [8];
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             load_we;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    out_d     = out_q;
    err_d     = err_q;
    load_we   = 1'b0;
    in_ready  = 1'b0;
    start     = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          // 3-bit counter wraps back to 0 on the eighth word
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start   = 1'b1;
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          out_d   = result;
          state_d = DELIVER;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = LOAD;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      DELIVER: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      wait_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < 8; k++) ops_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      out_q   <= out_d;
      err_q   <= err_d;
      if (load_we) ops_q[cnt_q] <= in_data;
    end
  end

  assign busy        = (state_q != LOAD);
  assign out_data    = out_q;
  assign timeout_err = err_q;
  assign i1 = ops_q[0];
  assign i2 = ops_q[1];
  assign i3 = ops_q[2];
  assign i4 = ops_q[3];
  assign i5 = ops_q[4];
  assign i6 = ops_q[5];
  assign i7 = ops_q[6];
  assign i8 = ops_q[7];
endmodule
